// File: rtl/aes_pkg.sv
// Shared types and widths for the AES core arbiter slice.
package aes_pkg;

  localparam int unsigned AES_BLK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant search starting after the stored
// pointer; the pointer moves to the winner when the grant is taken.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             upd,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  logic             found;
  int unsigned      pos;

  // First set request bit searching from ptr+1, wrapping modulo N.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    cand    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos  = (32'(ptr_q) + k) % N;
      cand = IDX_W'(pos);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd) ptr_d = gnt_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= IDX_W'(N - 1);
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES-128 core among NUM_REQ requesters: round-robin grant,
// one-cycle core start, completion wait with watchdog, held response.
module aes_core_arbiter
  import aes_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned BLK_W       = AES_BLK_W,
  parameter int unsigned TIMEOUT_CYC = 64,
  localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*BLK_W-1:0] req_pt,
  input  logic [NUM_REQ*BLK_W-1:0] req_key,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [BLK_W-1:0]         rsp_ct,
  output logic                     rsp_err,
  output logic                     core_valid,
  output logic [BLK_W-1:0]         core_pt,
  output logic [BLK_W-1:0]         core_key,
  input  logic                     core_complete,
  input  logic [BLK_W-1:0]         core_ct,
  output logic                     busy,
  output logic [IDX_W-1:0]         grant_id
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  arb_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                core_valid_q, core_valid_d;
  logic [BLK_W-1:0]    core_pt_q, core_pt_d;
  logic [BLK_W-1:0]    core_key_q, core_key_d;
  logic [IDX_W-1:0]    grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [BLK_W-1:0]    rsp_ct_q, rsp_ct_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_upd;
  logic [BLK_W-1:0]    sel_pt, sel_key;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .upd     (arb_upd),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Grant is visible only while idle, so at most one requester handshakes.
  assign req_ready = (state_q == IDLE) ? arb_gnt : '0;

  always_comb begin
    sel_pt  = '0;
    sel_key = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_pt  = req_pt[i*BLK_W +: BLK_W];
        sel_key = req_key[i*BLK_W +: BLK_W];
      end
    end
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    core_valid_d = 1'b0;
    core_pt_d    = core_pt_q;
    core_key_d   = core_key_q;
    grant_id_d   = grant_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_ct_d     = rsp_ct_q;
    rsp_err_d    = rsp_err_q;
    arb_upd      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          arb_upd      = 1'b1;
          grant_id_d   = arb_idx;
          core_pt_d    = sel_pt;
          core_key_d   = sel_key;
          core_valid_d = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Completion takes priority over a coincident watchdog expiry.
        cnt_d = cnt_inc;
        if (core_complete) begin
          rsp_ct_d    = core_ct;
          rsp_err_d   = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << grant_id_q;
          state_d     = RESP;
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYC - 1)) begin
          rsp_ct_d    = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = NUM_REQ'(1) << grant_id_q;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[grant_id_q]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      core_valid_q <= 1'b0;
      core_pt_q    <= '0;
      core_key_q   <= '0;
      grant_id_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_ct_q     <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_valid_q <= core_valid_d;
      core_pt_q    <= core_pt_d;
      core_key_q   <= core_key_d;
      grant_id_q   <= grant_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_ct_q     <= rsp_ct_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign core_valid = core_valid_q;
  assign core_pt    = core_pt_q;
  assign core_key   = core_key_q;
  assign grant_id   = grant_id_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_ct     = rsp_ct_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;

endmodule
